// File: rtl/l2_lookup_sched.sv
// L2 lookup scheduler: arbitrates CPU and forward lookups onto one
// tag/state read plus lookup-unit pass, one lookup in flight at a time.
module l2_lookup_sched #(
    parameter int SET_BITS   = 9,
    parameter int TAG_BITS   = 18,
    parameter int WAY_BITS   = 3,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [SET_BITS-1:0] req_set,
    input  logic [TAG_BITS-1:0] req_tag,
    input  logic                fwd_valid,
    output logic                fwd_ready,
    input  logic [SET_BITS-1:0] fwd_set,
    input  logic [TAG_BITS-1:0] fwd_tag,
    output logic                rd_en,
    output logic [SET_BITS-1:0] rd_set,
    output logic                lookup_en,
    output logic                lookup_mode,
    output logic [TAG_BITS-1:0] lookup_tag,
    input  logic                tag_hit,
    input  logic [WAY_BITS-1:0] way_hit,
    input  logic                empty_way_found,
    input  logic [WAY_BITS-1:0] empty_way,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_src,
    output logic                rsp_hit,
    output logic [WAY_BITS-1:0] rsp_way,
    output logic                rsp_empty_found,
    output logic [WAY_BITS-1:0] rsp_empty_way,
    output logic                busy
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        LKP,
        CAP,
        RSP
    } state_t;

    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    state_t              state;
    state_t              state_nx;
    logic [3:0]          starve_cnt;
    logic [3:0]          starve_nx;
    logic                gnt_req;
    logic                gnt_fwd;
    logic [SET_BITS-1:0] set_q;
    logic [TAG_BITS-1:0] tag_q;
    logic                src_q;
    logic [TAG_BITS-1:0] lk_tag_q;
    logic                lk_mode_q;

    always_comb begin
        state_nx  = state;
        starve_nx = starve_cnt;
        gnt_req   = 1'b0;
        gnt_fwd   = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_valid && (!fwd_valid || starve_cnt == SMAX)) begin
                    gnt_req   = 1'b1;
                    starve_nx = 4'd0;
                    state_nx  = RD;
                end else if (fwd_valid) begin
                    gnt_fwd  = 1'b1;
                    state_nx = RD;
                    // Count only fwd wins that actually made a req wait
                    if (!req_valid)
                        starve_nx = 4'd0;
                    else if (starve_cnt >= SMAX)
                        starve_nx = SMAX;
                    else
                        starve_nx = starve_cnt + 4'd1;
                end
            end
            RD:      state_nx = LKP;
            LKP:     state_nx = CAP;
            CAP:     state_nx = RSP;
            RSP:     if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            starve_cnt      <= 4'd0;
            set_q           <= '0;
            tag_q           <= '0;
            src_q           <= 1'b0;
            lk_tag_q        <= '0;
            lk_mode_q       <= 1'b0;
            rsp_src         <= 1'b0;
            rsp_hit         <= 1'b0;
            rsp_way         <= '0;
            rsp_empty_found <= 1'b0;
            rsp_empty_way   <= '0;
        end else begin
            state      <= state_nx;
            starve_cnt <= starve_nx;
            if (gnt_req || gnt_fwd) begin
                set_q <= gnt_req ? req_set : fwd_set;
                tag_q <= gnt_req ? req_tag : fwd_tag;
                src_q <= gnt_fwd;
            end
            if (state == RD) begin
                lk_mode_q <= src_q;
                lk_tag_q  <= tag_q;
            end
            // Forward lookups never allocate, so the empty-way result is dropped
            if (state == CAP) begin
                rsp_src         <= src_q;
                rsp_hit         <= tag_hit;
                rsp_way         <= way_hit;
                rsp_empty_found <= !src_q && empty_way_found;
                rsp_empty_way   <= src_q ? '0 : empty_way;
            end
        end
    end

    assign req_ready   = rst && gnt_req;
    assign fwd_ready   = rst && gnt_fwd;
    assign rd_en       = (state == RD);
    assign rd_set      = set_q;
    assign lookup_en   = (state == LKP);
    assign lookup_mode = lk_mode_q;
    assign lookup_tag  = lk_tag_q;
    assign rsp_valid   = (state == RSP);
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_l2_lookup_sched.sv
// Bench for l2_lookup_sched: cycle-level reference model plus directed
// scenarios with literal expectations.
module tb_l2_lookup_sched;

    localparam int SM = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [8:0]  req_set;
    logic [17:0] req_tag;
    logic        fwd_valid;
    logic        fwd_ready;
    logic [8:0]  fwd_set;
    logic [17:0] fwd_tag;
    logic        rd_en;
    logic [8:0]  rd_set;
    logic        lookup_en;
    logic        lookup_mode;
    logic [17:0] lookup_tag;
    logic        tag_hit;
    logic [2:0]  way_hit;
    logic        empty_way_found;
    logic [2:0]  empty_way;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_src;
    logic        rsp_hit;
    logic [2:0]  rsp_way;
    logic        rsp_empty_found;
    logic [2:0]  rsp_empty_way;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    l2_lookup_sched #(
        .SET_BITS(9), .TAG_BITS(18), .WAY_BITS(3), .STARVE_MAX(SM)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_set(req_set), .req_tag(req_tag),
        .fwd_valid(fwd_valid), .fwd_ready(fwd_ready),
        .fwd_set(fwd_set), .fwd_tag(fwd_tag),
        .rd_en(rd_en), .rd_set(rd_set),
        .lookup_en(lookup_en), .lookup_mode(lookup_mode),
        .lookup_tag(lookup_tag),
        .tag_hit(tag_hit), .way_hit(way_hit),
        .empty_way_found(empty_way_found), .empty_way(empty_way),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_src(rsp_src), .rsp_hit(rsp_hit), .rsp_way(rsp_way),
        .rsp_empty_found(rsp_empty_found), .rsp_empty_way(rsp_empty_way),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {req_ready, fwd_ready, rd_en, rd_set, lookup_en, lookup_mode,
                lookup_tag, rsp_valid, rsp_src, rsp_hit, rsp_way,
                rsp_empty_found, rsp_empty_way, busy};
    endfunction

    // Lookup unit stand-in: result bits are a fixed function of the tag
    initial begin
        tag_hit = 0; way_hit = 0; empty_way_found = 0; empty_way = 0;
        forever begin
            @(negedge clk);
            if (lookup_en) begin
                tag_hit         = lookup_tag[3];
                way_hit         = lookup_tag[2:0];
                empty_way_found = lookup_tag[4];
                empty_way       = lookup_tag[7:5];
            end
        end
    end

    // Reference model: ph = cycles since grant (0 = idle)
    int          ph = 0;
    int          m_cnt = 0;
    logic        m_src = 0;
    logic [8:0]  m_set = 0;
    logic [17:0] m_tag = 0;
    logic        m_lkmode = 0;
    logic [17:0] m_lktag = 0;
    logic        m_rsrc = 0, m_hit = 0, m_ef = 0;
    logic [2:0]  m_way = 0, m_ew = 0;
    logic        er, ef;
    bit          grants[$];

    always @(negedge clk) begin
        if (!rst) begin
            chk("reset_outs", all_outs(), 64'd0);
            ph = 0; m_cnt = 0; m_src = 0; m_set = 0; m_tag = 0;
            m_lkmode = 0; m_lktag = 0;
            m_rsrc = 0; m_hit = 0; m_ef = 0; m_way = 0; m_ew = 0;
        end else begin
            er = (ph == 0) && req_valid && (!fwd_valid || m_cnt == SM);
            ef = (ph == 0) && fwd_valid && !er;
            chk("m_req_ready", req_ready, er);
            chk("m_fwd_ready", fwd_ready, ef);
            chk("m_rd_en", rd_en, ph == 1);
            chk("m_rd_set", rd_set, m_set);
            chk("m_lookup_en", lookup_en, ph == 2);
            chk("m_lookup_mode", lookup_mode, m_lkmode);
            chk("m_lookup_tag", lookup_tag, m_lktag);
            chk("m_rsp_valid", rsp_valid, ph == 4);
            chk("m_rsp_fields", {rsp_src, rsp_hit, rsp_way,
                                 rsp_empty_found, rsp_empty_way},
                {m_rsrc, m_hit, m_way, m_ef, m_ew});
            chk("m_busy", busy, ph != 0);
            if (req_ready && req_valid) grants.push_back(1'b0);
            if (fwd_ready && fwd_valid) grants.push_back(1'b1);
            case (ph)
                0: if (er) begin
                    m_src = 0; m_set = req_set; m_tag = req_tag;
                    m_cnt = 0; ph = 1;
                end else if (ef) begin
                    m_src = 1; m_set = fwd_set; m_tag = fwd_tag;
                    m_cnt = !req_valid ? 0 : (m_cnt + 1 > SM ? SM : m_cnt + 1);
                    ph = 1;
                end
                1: begin m_lkmode = m_src; m_lktag = m_tag; ph = 2; end
                2: ph = 3;
                3: begin
                    m_rsrc = m_src;
                    m_hit  = m_tag[3];
                    m_way  = m_tag[2:0];
                    m_ef   = m_src ? 1'b0 : m_tag[4];
                    m_ew   = m_src ? 3'd0 : m_tag[7:5];
                    ph = 4;
                end
                default: if (rsp_ready) ph = 0;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 50) begin
            tick();
            n++;
        end
        if (busy) chk("idle_timeout", 1, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        logic [2:0] snap_way;
        int n;
        rst = 0; rsp_ready = 1;
        fwd_valid = 0; fwd_set = 0; fwd_tag = 0;
        req_valid = 1; req_set = 9'h012; req_tag = 18'h3ABCD;
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_busy", busy, 0);
        tick();
        rst = 1;
        // single req: grant, then literal latency pins
        @(negedge clk);
        chk("t0_req_ready", req_ready, 1);
        tick();
        req_valid = 0;
        @(negedge clk);
        chk("t1_rd", {rd_en, rd_set}, {1'b1, 9'h012});
        tick(); @(negedge clk);
        chk("t2_lkp", {lookup_en, lookup_mode, lookup_tag},
            {1'b1, 1'b0, 18'h3ABCD});
        tick(); @(negedge clk);
        chk("t3_no_rsp", rsp_valid, 0);
        tick(); @(negedge clk);
        chk("t4_rsp", {rsp_valid, rsp_src, rsp_hit, rsp_way},
            {1'b1, 1'b0, 1'b1, 3'd5});

        // fwd lookup drops the empty-way result
        tick(); wait_idle();
        fwd_valid = 1; fwd_set = 9'h1AB; fwd_tag = 18'h00050;
        @(negedge clk);
        chk("f0_ready", {fwd_ready, req_ready}, {1'b1, 1'b0});
        tick();
        fwd_valid = 0;
        tick(); @(negedge clk);
        chk("f2_mode", {lookup_en, lookup_mode, lookup_tag},
            {1'b1, 1'b1, 18'h00050});
        tick(); tick(); @(negedge clk);
        chk("f4_rsp", {rsp_valid, rsp_src, rsp_empty_found, rsp_empty_way},
            {1'b1, 1'b1, 1'b0, 3'd0});

        // starvation: both valid continuously
        tick(); wait_idle();
        grants.delete();
        req_valid = 1; req_set = 9'h003; req_tag = 18'h00111;
        fwd_valid = 1; fwd_set = 9'h004; fwd_tag = 18'h00222;
        n = 0;
        while (grants.size() < 10 && n < 100) begin
            @(negedge clk);
            n++;
        end
        tick();
        req_valid = 0; fwd_valid = 0;
        chk("starve_count", grants.size(), 10);
        for (int i = 0; i < 10 && i < grants.size(); i++)
            chk($sformatf("grant_order_%0d", i), grants[i], (i % 5) != 4);

        // stalled response with a pending req
        wait_idle();
        rsp_ready = 0;
        req_valid = 1; req_set = 9'h055; req_tag = 18'h01234;
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("stall_rsp_seen", rsp_valid, 1);
        chk("stall_fields", {rsp_hit, rsp_way, rsp_empty_found, rsp_empty_way},
            {1'b0, 3'd4, 1'b1, 3'd1});
        snap_way = rsp_way;
        for (int i = 0; i < 10; i++) begin
            chk("stall_req_ready", req_ready, 0);
            chk("stall_way", rsp_way, snap_way);
            tick(); @(negedge clk);
        end
        tick();
        rsp_ready = 1;
        @(negedge clk);
        chk("hs_cycle", {rsp_valid, req_ready}, {1'b1, 1'b0});
        tick(); @(negedge clk);
        chk("post_hs_grant", req_ready, 1);
        tick();
        req_valid = 0;

        // reset in LKP aborts the lookup
        wait_idle();
        req_valid = 1; req_set = 9'h0AA; req_tag = 18'h2F00F;
        @(negedge clk);
        tick();
        req_valid = 0;
        tick(); @(negedge clk);
        chk("abort_lkp", lookup_en, 1);
        #2 rst = 0;
        #1 chk("async_reset_outs", all_outs(), 64'd0);
        tick(); tick();
        rst = 1;
        repeat (6) begin
            @(negedge clk);
            chk("abort_no_rsp", rsp_valid, 0);
        end
        tick();
        req_valid = 1;
        @(negedge clk);
        chk("r0_ready", req_ready, 1);
        tick();
        req_valid = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("r4_rsp", {rsp_valid, rsp_src, rsp_hit, rsp_way, rsp_empty_found},
            {1'b1, 1'b0, 1'b1, 3'd7, 1'b0});
        tick(); wait_idle();
        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
